// File: rtl/game_history_stack_if.sv
// game_history_stack_if: undo-history bus between game_controller (master) and game_history_stack (slave)
interface game_history_stack_if #(
  parameter int W  = 134,
  parameter int AW = 3
);
  logic         clear;
  logic         push;
  logic [W-1:0] push_state;
  logic         pop;
  logic [W-1:0] pop_state;
  logic         pop_valid;
  logic         pop_nack;
  logic         real_retract;
  logic         full;
  logic [AW:0]  count;
  modport master (
    output clear, push, push_state, pop,
    input  pop_state, pop_valid, pop_nack, real_retract, full, count
  );
  modport slave (
    input  clear, push, push_state, pop,
    output pop_state, pop_valid, pop_nack, real_retract, full, count
  );
endinterface

// File: rtl/game_history_stack.sv
// game_history_stack: bounded LIFO ring of game_state snapshots (clk, reset, bus s: clear/push/pop in, pop_state/pop_valid/pop_nack/real_retract/full/count out)
module game_history_stack #(
  parameter int W     = 134,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic clk,
  input logic reset,
  game_history_stack_if.slave s
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic [W-1:0]  pop_state;
  logic          pop_valid;
  logic          pop_nack;
  logic          full;
  logic [AW-1:0] rd_ptr;
  assign full           = cnt == (AW+1)'(DEPTH);
  assign rd_ptr         = wr_ptr - AW'(1);
  assign s.count        = cnt;
  assign s.full         = full;
  assign s.real_retract = cnt != '0;
  assign s.pop_state    = pop_state;
  assign s.pop_valid    = pop_valid;
  assign s.pop_nack     = pop_nack;
  always_ff @(posedge clk)
    if (!reset && !s.clear && s.push) mem[wr_ptr] <= s.push_state;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      cnt       <= '0;
      pop_state <= '0;
      pop_valid <= 1'b0;
      pop_nack  <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      pop_nack  <= 1'b0;
      if (s.clear) begin
        wr_ptr <= '0;
        cnt    <= '0;
      end else if (s.push) begin
        wr_ptr <= wr_ptr + AW'(1);
        cnt    <= full ? cnt : cnt + (AW+1)'(1);
      end else if (s.pop) begin
        if (cnt != '0) begin
          wr_ptr    <= rd_ptr;
          cnt       <= cnt - (AW+1)'(1);
          pop_state <= mem[rd_ptr];
          pop_valid <= 1'b1;
        end else begin
          pop_nack <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_game_history_stack.sv
// tb_game_history_stack: directed scoreboard bench for game_history_stack
module tb_game_history_stack;
  localparam int W = 134;
  localparam int DEPTH = 8;
  typedef struct {
    logic [1:0]   kind;
    logic [W-1:0] val;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] last_pop = '0;
  game_history_stack_if #(.W(W), .AW(3)) bus ();
  game_history_stack #(.W(W), .DEPTH(DEPTH), .AW(3)) dut (
    .clk(clk),
    .reset(reset),
    .s(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_status(input string tag);
    chk({tag, ".count"}, W'(bus.count), W'(hist.size()));
    chk({tag, ".real_retract"}, W'(bus.real_retract), W'(hist.size() != 0));
    chk({tag, ".full"}, W'(bus.full), W'(hist.size() == DEPTH));
  endtask
  task automatic cyc(input string tag, input logic pu, input logic [W-1:0] v, input logic po, input logic cl);
    exp_t e;
    exp_t got;
    @(negedge clk);
    bus.push = pu;
    bus.push_state = v;
    bus.pop = po;
    bus.clear = cl;
    e.kind = 2'd0;
    e.val = last_pop;
    if (cl) hist.delete();
    else if (pu) begin
      hist.push_back(v);
      if (hist.size() > DEPTH) void'(hist.pop_front());
    end else if (po) begin
      if (hist.size() > 0) begin
        e.kind = 2'd1;
        e.val = hist.pop_back();
        last_pop = e.val;
      end else e.kind = 2'd2;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.clear = 1'b0;
    got = sb.pop_front();
    chk({tag, ".pop_valid"}, W'(bus.pop_valid), W'(got.kind == 2'd1));
    chk({tag, ".pop_nack"}, W'(bus.pop_nack), W'(got.kind == 2'd2));
    chk({tag, ".pop_state"}, bus.pop_state, got.val);
    chk_status(tag);
  endtask
  task automatic idle(input string tag);
    cyc(tag, 1'b0, '0, 1'b0, 1'b0);
  endtask
  initial begin
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.clear = 1'b0;
    bus.push_state = '0;
    #12;
    chk_status("reset");
    chk("reset.pop_valid", W'(bus.pop_valid), '0);
    chk("reset.pop_nack", W'(bus.pop_nack), '0);
    chk("reset.pop_state", bus.pop_state, '0);
    @(negedge clk);
    reset = 1'b0;
    cyc("t3.pop_empty", 1'b0, '0, 1'b1, 1'b0);
    idle("t3.after");
    for (int i = 1; i <= 3; i++) cyc("t1.push", 1'b1, W'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("t1.pop", 1'b0, '0, 1'b1, 1'b0);
    idle("t1.after");
    for (int i = 1; i <= 10; i++) cyc("t2.push", 1'b1, W'(i), 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cyc("t2.pop", 1'b0, '0, 1'b1, 1'b0);
    cyc("t4.push5", 1'b1, W'(5), 1'b0, 1'b0);
    cyc("t4.push6", 1'b1, W'(6), 1'b0, 1'b0);
    cyc("t4.push_pop", 1'b1, W'(7), 1'b1, 1'b0);
    cyc("t4.pop", 1'b0, '0, 1'b1, 1'b0);
    cyc("t4.wide", 1'b1, {6'h2a, {32{4'hc}}}, 1'b0, 1'b0);
    cyc("t4.wide_pop", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc("t5.push", 1'b1, W'(20 + i), 1'b0, 1'b0);
    cyc("t5.clear_push", 1'b1, W'(99), 1'b0, 1'b1);
    cyc("t5.pop", 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("t6.push", 1'b1, W'(40 + i), 1'b0, 1'b0);
    @(negedge clk);
    bus.pop = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    hist.delete();
    last_pop = '0;
    chk_status("t6.async");
    @(posedge clk);
    #1;
    bus.pop = 1'b0;
    chk("t6.pop_valid", W'(bus.pop_valid), '0);
    chk("t6.pop_nack", W'(bus.pop_nack), '0);
    chk("t6.pop_state", bus.pop_state, '0);
    @(negedge clk);
    reset = 1'b0;
    cyc("t6.push9", 1'b1, W'(9), 1'b0, 1'b0);
    cyc("t6.pop9", 1'b0, '0, 1'b1, 1'b0);
    idle("t6.after");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/game_history_stack.md
Name: game_history_stack

Overview:
Stores the undo history for the Sokoban core. game_controller pushes the packed game_state {way, box, man} before each successful move. On a retract it pops the most recent snapshot. The block answers each pop with either the restored state or a refusal, and drives real_retract back to the controller so it knows whether a retract is possible. The buffer is a bounded LIFO ring: once full, each new push silently discards the oldest entry.

Parameters:
W, 134, snapshot width (way[63:0], box[63:0], man[5:0]).
DEPTH, 8, number of retractable moves kept; power of two, minimum 2.
AW, 3, pointer width, equal to log2(DEPTH).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
clear  in  1  synchronous history flush, pulsed on retry, stage change or next level.
push  in  1  one-cycle request to store push_state.
push_state  in  W  snapshot to store.
pop  in  1  one-cycle retract request.
pop_state  out  W  restored snapshot; valid only while pop_valid is high.
pop_valid  out  1  one-cycle pulse: pop_state holds the popped entry.
pop_nack  out  1  one-cycle pulse: pop was refused because the history was empty.
real_retract  out  1  high when at least one entry is stored (count != 0).
full  out  1  high when count == DEPTH.
count  out  AW+1  number of stored entries, 0..DEPTH.

Behaviour:
- Storage: mem[DEPTH] of W bits; wr_ptr (AW bits) points to the next write slot; count is AW+1 bits.
- Asynchronous reset: wr_ptr, count, pop_state, pop_valid and pop_nack all go to 0. Resulting outputs: real_retract 0, full 0, count 0. Mem contents need not be reset.
- Reset asserted mid-operation aborts everything: no partial write, and no pop_valid or pop_nack pulse is generated.
- Priority each cycle is clear > push > pop.
- clear: on the next edge wr_ptr=0 and count=0; pop_valid and pop_nack are 0 that cycle. Any push or pop in the same cycle is ignored. pop_state holds its last value.
- push without full: mem[wr_ptr]<=push_state, wr_ptr<=wr_ptr+1 (mod DEPTH), count<=count+1.
- push with full: same write and pointer increment, but count stays DEPTH. The write overwrites the oldest entry.
- pop when count>0 and no push or clear that cycle:
  - wr_ptr<=wr_ptr-1 (mod DEPTH; 0 wraps to DEPTH-1) and count<=count-1.
  - pop_state<=mem[wr_ptr-1] and pop_valid<=1 for exactly one cycle.
  - Latency: pop sampled at edge N, data and pop_valid visible after edge N.
- pop when count==0 and no push or clear: pop_nack<=1 for one cycle; pop_valid stays 0; pointers and pop_state are unchanged.
- push and pop in the same cycle: the push is performed and the pop is dropped, with no pop_valid and no pop_nack. The controller never issues both, but the behaviour is defined.
- pop_valid and pop_nack are mutually exclusive and return to 0 one cycle after they assert.
- pop held high for several cycles: each cycle is a separate pop request; there is no edge detection inside the block.
- real_retract and full are combinational from the count register, so they update on the same edge as count.
- No read-during-write hazard exists, because push and pop are never both performed in one cycle.

Test Plan:
1. Reset, then push A=1, B=2, C=3, then pop three times -> pop_state 3, 2, 1 with one pop_valid pulse each; count ends at 0 and real_retract falls after the third pop.
2. DEPTH=8: push values 1..10, then pop nine times -> full=1 and count=8 after the pushes; pops return 10, 9, ..., 3; the ninth pop gives pop_nack=1 and pop_valid=0.
3. From reset, pop once -> pop_nack pulses for one cycle; count stays 0 and pop_state stays 0.
4. Push 5 and 6, then push 7 and pop in the same cycle -> count=3 and no pop_valid or pop_nack; a following pop returns 7.
5. Push 4 entries, then clear with push asserted in the same cycle -> count=0 and real_retract=0; the next pop gives pop_nack.
6. Push 3 entries, then assert reset asynchronously between clock edges while pop is high -> count, full and real_retract go to 0 immediately and no pop_valid is emitted; after release, push 9 then pop returns 9.
